ex_stage_pipe: RTL and testbench

Parametrised execute stage for the pipelined MIPS core. It generalises the single-cycle EX block in four ways:
- configurable datapath width;
- valid/ready handshakes on both sides;
- registered branch resolution, covering beq and bne;
- an iterative multi-cycle multiplier for MULT.

It sits between the ID/EX register and the MEM stage, and sends its branch outcome back to the fetch stage.

---
 rtl/ex_stage_pipe.sv | 225 ++++++++++++++++++++++
 tb/tb_ex_stage_pipe.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage_pipe.sv
// Execute stage of the pipelined MIPS core: ALU, beq/bne resolution and an
// iterative shift-add multiplier, with valid/ready handshakes on both sides.
module ex_stage_pipe #(
    parameter int XLEN     = 32,
    parameter int MUL_STEP = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] rs,
    input  logic [XLEN-1:0] rt,
    input  logic [XLEN-1:0] sign_ext,
    input  logic [XLEN-1:0] pc,
    input  logic            alu_src,
    input  logic [1:0]      alu_op,
    input  logic [5:0]      funct,
    input  logic            branch,
    input  logic            is_bne,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            carry,
    output logic            branch_taken,
    output logic [XLEN-1:0] branch_target
);
    localparam int NSTEP = XLEN / MUL_STEP;
    localparam int CW    = $clog2(NSTEP + 1);

    // HOLD means a result sits in the output registers waiting for out_ready.
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL_BUSY = 2'd1, S_HOLD = 2'd2} state_t;
    typedef enum logic [3:0] {
        OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR = 4'd3, OP_XOR = 4'd4,
        OP_NOR = 4'd5, OP_SLT = 4'd6, OP_SLTU = 4'd7, OP_MUL = 4'd8
    } op_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] mul_mcand_q, mul_mplier_q, mul_acc_q;
    logic [CW-1:0]   mul_cnt_q;
    logic            out_valid_q, zero_q, carry_q, branch_taken_q;
    logic [XLEN-1:0] result_q, branch_target_q;

    logic [XLEN-1:0] b_s, alu_res_s, step_sum_s, target_s;
    logic [XLEN:0]   add_s;
    logic            alu_carry_s, accept_s, last_step_s;
    op_t             op_s;

    assign b_s         = alu_src ? sign_ext : rt;
    assign add_s       = {1'b0, rs} + {1'b0, b_s};
    assign target_s    = pc + (sign_ext << 2);
    assign accept_s    = in_valid && in_ready && !flush;
    assign last_step_s = (state_q == S_MUL_BUSY) && (mul_cnt_q == CW'(1));

    // Operation decode; a branch always compares by subtraction.
    always_comb begin
        op_s = OP_ADD;
        if (branch) begin
            op_s = OP_SUB;
        end else begin
            case (alu_op)
                2'b01: op_s = OP_SUB;
                2'b10: begin
                    case (funct)
                        6'h22:   op_s = OP_SUB;
                        6'h24:   op_s = OP_AND;
                        6'h25:   op_s = OP_OR;
                        6'h26:   op_s = OP_XOR;
                        6'h27:   op_s = OP_NOR;
                        6'h2A:   op_s = OP_SLT;
                        6'h2B:   op_s = OP_SLTU;
                        6'h18:   op_s = OP_MUL;
                        default: op_s = OP_ADD;
                    endcase
                end
                default: op_s = OP_ADD;
            endcase
        end
    end

    // Single-cycle ALU result and carry/no-borrow flag.
    always_comb begin
        alu_res_s   = add_s[XLEN-1:0];
        alu_carry_s = 1'b0;
        case (op_s)
            OP_ADD:  alu_carry_s = add_s[XLEN];
            OP_SUB: begin
                alu_res_s   = rs - b_s;
                alu_carry_s = (rs >= b_s);
            end
            OP_AND:  alu_res_s = rs & b_s;
            OP_OR:   alu_res_s = rs | b_s;
            OP_XOR:  alu_res_s = rs ^ b_s;
            OP_NOR:  alu_res_s = ~(rs | b_s);
            OP_SLT: begin
                alu_res_s   = {{(XLEN-1){1'b0}}, ($signed(rs) < $signed(b_s))};
                alu_carry_s = (rs >= b_s);
            end
            OP_SLTU: begin
                alu_res_s   = {{(XLEN-1){1'b0}}, (rs < b_s)};
                alu_carry_s = (rs >= b_s);
            end
            default: begin
                alu_res_s   = add_s[XLEN-1:0];
                alu_carry_s = 1'b0;
            end
        endcase
    end

    // One multiplier slice: add the shifted multiplicand for each set low bit.
    always_comb begin
        step_sum_s = mul_acc_q;
        for (int j = 0; j < MUL_STEP; j++) begin
            if (mul_mplier_q[j]) begin
                step_sum_s = step_sum_s + (mul_mcand_q << j);
            end else begin
                step_sum_s = step_sum_s;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_HOLD: begin
                    if (accept_s) begin
                        state_d = (op_s == OP_MUL) ? S_MUL_BUSY : S_HOLD;
                    end else if (out_ready || !out_valid_q) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_HOLD;
                    end
                end
                S_MUL_BUSY: state_d = last_step_s ? S_HOLD : S_MUL_BUSY;
                default:    state_d = S_IDLE;
            endcase
        end
    end

    // Upstream ready: a held result may be drained and replaced on the same edge.
    always_comb begin
        in_ready = (state_q != S_MUL_BUSY) && (!out_valid_q || out_ready);
    end

    // Multiplier operand, accumulator and step counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mul_mcand_q  <= {XLEN{1'b0}};
            mul_mplier_q <= {XLEN{1'b0}};
            mul_acc_q    <= {XLEN{1'b0}};
            mul_cnt_q    <= {CW{1'b0}};
        end else if (flush) begin
            mul_acc_q <= {XLEN{1'b0}};
            mul_cnt_q <= {CW{1'b0}};
        end else if (accept_s && (op_s == OP_MUL)) begin
            mul_mcand_q  <= rs;
            mul_mplier_q <= b_s;
            mul_acc_q    <= {XLEN{1'b0}};
            mul_cnt_q    <= CW'(NSTEP);
        end else if (state_q == S_MUL_BUSY) begin
            mul_mcand_q  <= mul_mcand_q << MUL_STEP;
            mul_mplier_q <= mul_mplier_q >> MUL_STEP;
            mul_acc_q    <= step_sum_s;
            mul_cnt_q    <= mul_cnt_q - CW'(1);
        end else begin
            mul_cnt_q <= mul_cnt_q;
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_q     <= 1'b0;
            result_q        <= {XLEN{1'b0}};
            zero_q          <= 1'b0;
            carry_q         <= 1'b0;
            branch_taken_q  <= 1'b0;
            branch_target_q <= {XLEN{1'b0}};
        end else if (flush) begin
            out_valid_q    <= 1'b0;
            branch_taken_q <= 1'b0;
        end else if (accept_s && (op_s == OP_MUL)) begin
            out_valid_q     <= 1'b0;
            branch_taken_q  <= 1'b0;
            branch_target_q <= target_s;
        end else if (accept_s) begin
            out_valid_q     <= 1'b1;
            result_q        <= alu_res_s;
            zero_q          <= (alu_res_s == {XLEN{1'b0}});
            carry_q         <= alu_carry_s;
            branch_taken_q  <= branch && ((alu_res_s == {XLEN{1'b0}}) ^ is_bne);
            branch_target_q <= target_s;
        end else if (last_step_s) begin
            out_valid_q <= 1'b1;
            result_q    <= step_sum_s;
            zero_q      <= (step_sum_s == {XLEN{1'b0}});
            carry_q     <= 1'b0;
        end else if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= out_valid_q;
        end
    end

    assign out_valid     = out_valid_q;
    assign result        = result_q;
    assign zero          = zero_q;
    assign carry         = carry_q;
    assign branch_taken  = branch_taken_q;
    assign branch_target = branch_target_q;
endmodule

// File: tb/tb_ex_stage_pipe.sv
// Self-checking bench for ex_stage_pipe: directed scenarios plus a randomized
// run scored against a transaction-level reference model.
module tb_ex_stage_pipe;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, in_valid, in_ready, alu_src, branch, is_bne, flush;
    logic        out_valid, out_ready, zero, carry, branch_taken;
    logic [31:0] rs, rt, sign_ext, pc, result, branch_target;
    logic [1:0]  alu_op;
    logic [5:0]  funct;

    logic        h_reset, h_in_valid, h_in_ready, h_alu_src, h_branch, h_is_bne, h_flush;
    logic        h_out_valid, h_out_ready, h_zero, h_carry, h_branch_taken;
    logic [15:0] h_rs, h_rt, h_sign_ext, h_pc, h_result, h_branch_target;
    logic [1:0]  h_alu_op;
    logic [5:0]  h_funct;

    int n_checks = 0;
    int n_fail   = 0;

    ex_stage_pipe #(.XLEN(32), .MUL_STEP(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .rs(rs), .rt(rt), .sign_ext(sign_ext), .pc(pc), .alu_src(alu_src),
        .alu_op(alu_op), .funct(funct), .branch(branch), .is_bne(is_bne),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .carry(carry),
        .branch_taken(branch_taken), .branch_target(branch_target)
    );

    ex_stage_pipe #(.XLEN(16), .MUL_STEP(4)) dut16 (
        .clk(clk), .reset(h_reset), .in_valid(h_in_valid), .in_ready(h_in_ready),
        .rs(h_rs), .rt(h_rt), .sign_ext(h_sign_ext), .pc(h_pc), .alu_src(h_alu_src),
        .alu_op(h_alu_op), .funct(h_funct), .branch(h_branch), .is_bne(h_is_bne),
        .flush(h_flush), .out_valid(h_out_valid), .out_ready(h_out_ready),
        .result(h_result), .zero(h_zero), .carry(h_carry),
        .branch_taken(h_branch_taken), .branch_target(h_branch_target)
    );

    typedef struct packed {
        logic [31:0] res;
        logic        z;
        logic        c;
        logic        tk;
        logic [31:0] tgt;
        logic        mul;
    } exp_t;

    // Reference: architectural meaning of one instruction in plain arithmetic.
    function automatic exp_t ref_exec(input logic [31:0] a, input logic [31:0] b,
                                      input logic [31:0] pcv, input logic [31:0] se,
                                      input logic [1:0] op, input logic [5:0] f,
                                      input logic br, input logic bne);
        exp_t        e;
        logic [5:0]  fe;
        logic [32:0] w;
        logic [63:0] p;
        if (br || op == 2'b01) fe = 6'h22;
        else if (op == 2'b10)  fe = f;
        else                   fe = 6'h20;
        e = '0;
        case (fe)
            6'h22: begin e.res = a - b; e.c = (a >= b); end
            6'h24: e.res = a & b;
            6'h25: e.res = a | b;
            6'h26: e.res = a ^ b;
            6'h27: e.res = ~(a | b);
            6'h2A: begin e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; e.c = (a >= b); end
            6'h2B: begin e.res = (a < b) ? 32'd1 : 32'd0; e.c = (a >= b); end
            6'h18: begin p = {32'd0, a} * {32'd0, b}; e.res = p[31:0]; e.mul = 1'b1; end
            default: begin w = {1'b0, a} + {1'b0, b}; e.res = w[31:0]; e.c = w[32]; end
        endcase
        e.z   = (e.res == 32'd0);
        e.tk  = br && (e.z != bne);
        e.tgt = pcv + se * 32'd4;
        return e;
    endfunction

    task automatic idle32();
        in_valid = 1'b0; flush = 1'b0; branch = 1'b0; is_bne = 1'b0; alu_src = 1'b0;
        alu_op = 2'b00; funct = 6'h00; rs = 32'd0; rt = 32'd0; sign_ext = 32'd0;
        pc = 32'd0; out_ready = 1'b1;
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] op, input logic [5:0] f);
        in_valid = 1'b1; rs = a; rt = b; alu_op = op; funct = f;
        alu_src = 1'b0; branch = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; h_reset = 1'b1;
        #1 reset = 1'b0; h_reset = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, result, zero, carry, branch_taken, branch_target} !== 67'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {out_valid, result, zero, carry, branch_taken, branch_target});
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        @(negedge clk);
        reset = 1'b1; h_reset = 1'b1;
    endtask

    task automatic test_add();
        @(negedge clk);
        issue(32'hFFFF_FFFF, 32'd1, 2'b10, 6'h20);
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if ({out_valid, result, zero, carry} !== {1'b1, 32'd0, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL add_wrap: got v=%b r=%h z=%b c=%b expected v=1 r=0 z=1 c=1",
                     out_valid, result, zero, carry);
        end
    endtask

    task automatic test_branch();
        @(negedge clk);
        issue(32'd5, 32'd5, 2'b01, 6'h00);
        branch = 1'b1; is_bne = 1'b0; pc = 32'h100; sign_ext = 32'hFFFF_FFFE;
        @(negedge clk);
        n_checks++;
        if ({out_valid, branch_taken, branch_target} !== {1'b1, 1'b1, 32'h0000_00F8}) begin
            n_fail++;
            $display("FAIL beq_taken: got v=%b t=%b tgt=%h expected v=1 t=1 tgt=000000f8",
                     out_valid, branch_taken, branch_target);
        end
        is_bne = 1'b1;
        @(negedge clk);
        idle32();
        n_checks++;
        if ({out_valid, branch_taken, branch_target} !== {1'b1, 1'b0, 32'h0000_00F8}) begin
            n_fail++;
            $display("FAIL bne_not_taken: got v=%b t=%b tgt=%h expected v=1 t=0 tgt=000000f8",
                     out_valid, branch_taken, branch_target);
        end
    endtask

    task automatic test_mult();
        bit bad = 1'b0;
        @(negedge clk);
        issue(32'h0001_2345, 32'h100, 2'b10, 6'h18);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (in_ready !== 1'b0 || out_valid !== 1'b0) bad = 1'b1;
        end
        n_checks++;
        if (bad) begin
            n_fail++; $display("FAIL mult_busy: in_ready/out_valid not 0 during busy, expected 0");
        end
        @(negedge clk);
        n_checks++;
        if ({out_valid, result, carry} !== {1'b1, 32'h0123_4500, 1'b0}) begin
            n_fail++;
            $display("FAIL mult_result: got v=%b r=%h c=%b expected v=1 r=01234500 c=0",
                     out_valid, result, carry);
        end
    endtask

    task automatic test_backpressure();
        bit bad = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        issue(32'd3, 32'd4, 2'b10, 6'h20);
        @(negedge clk);
        issue(32'd20, 32'd5, 2'b01, 6'h00);
        for (int k = 0; k < 3; k++) begin
            #1;
            if (in_ready !== 1'b0) bad = 1'b1;
            @(negedge clk);
            if ({out_valid, result, zero, carry, branch_taken, branch_target} !==
                {1'b1, 32'd7, 1'b0, 1'b0, 1'b0, 32'd0}) bad = 1'b1;
        end
        n_checks++;
        if (bad) begin
            n_fail++; $display("FAIL hold_stable: outputs moved or in_ready=1 during stall, expected r=7 held");
        end
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL hold_release_ready: got %b expected 1", in_ready);
        end
        @(negedge clk);
        idle32();
        n_checks++;
        if ({out_valid, result, carry} !== {1'b1, 32'd15, 1'b1}) begin
            n_fail++;
            $display("FAIL back_to_back: got v=%b r=%h c=%b expected v=1 r=0000000f c=1",
                     out_valid, result, carry);
        end
    endtask

    task automatic test_flush();
        bit bad = 1'b0;
        @(negedge clk);
        issue(32'h1234, 32'h5678, 2'b10, 6'h18);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        flush = 1'b1;
        issue(32'd1, 32'd1, 2'b10, 6'h20);
        @(negedge clk);
        idle32();
        #1;
        n_checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++; $display("FAIL flush_mult: got v=%b rdy=%b expected v=0 rdy=1", out_valid, in_ready);
        end
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) bad = 1'b1;
        end
        n_checks++;
        if (bad) begin
            n_fail++; $display("FAIL flush_abort: out_valid rose after flush, expected 0");
        end
        issue(32'd7, 32'd9, 2'b01, 6'h00);
        @(negedge clk);
        idle32();
        n_checks++;
        if ({out_valid, result, zero, carry} !== {1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL sub_after_flush: got v=%b r=%h z=%b c=%b expected v=1 r=fffffffe z=0 c=0",
                     out_valid, result, zero, carry);
        end
        @(negedge clk);
        out_ready = 1'b0;
        issue(32'd2, 32'd3, 2'b10, 6'h20);
        @(negedge clk);
        flush = 1'b1; out_ready = 1'b1;
        issue(32'd4, 32'd4, 2'b10, 6'h20);
        @(negedge clk);
        idle32();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL flush_hold: got v=%b expected 0", out_valid);
        end
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL flush_ignores_in_valid: got v=%b expected 0", out_valid);
        end
    endtask

    task automatic test_random();
        exp_t        cur, pend, e;
        bit          m_valid = 1'b0;
        int          busy = 0;
        logic        exp_ready;
        logic [5:0]  ftab [10] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B, 6'h18, 6'h3F};
        repeat (2) @(negedge clk);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== m_valid) begin
                n_fail++; $display("FAIL rnd_valid[%0d]: got %b expected %b", i, out_valid, m_valid);
            end
            if (m_valid) begin
                n_checks++;
                if ({result, zero, carry, branch_taken, branch_target} !==
                    {cur.res, cur.z, cur.c, cur.tk, cur.tgt}) begin
                    n_fail++;
                    $display("FAIL rnd_result[%0d]: got r=%h z=%b c=%b t=%b tgt=%h expected r=%h z=%b c=%b t=%b tgt=%h",
                             i, result, zero, carry, branch_taken, branch_target,
                             cur.res, cur.z, cur.c, cur.tk, cur.tgt);
                end
            end
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            rs = $urandom; rt = $urandom; sign_ext = $urandom; pc = $urandom;
            alu_src = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 5) == 0) begin rt = rs; alu_src = 1'b0; end
            alu_op = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 0) alu_op = 2'b10;
            funct  = ftab[$urandom_range(0, 9)];
            branch = ($urandom_range(0, 5) == 0);
            is_bne = 1'($urandom_range(0, 1));
            #1;
            exp_ready = (busy == 0) && (!m_valid || out_ready);
            n_checks++;
            if (in_ready !== exp_ready) begin
                n_fail++; $display("FAIL rnd_ready[%0d]: got %b expected %b", i, in_ready, exp_ready);
            end
            if (m_valid && out_ready) m_valid = 1'b0;
            if (busy > 0) begin
                busy--;
                if (busy == 0) begin cur = pend; m_valid = 1'b1; end
            end else if (in_valid && exp_ready) begin
                e = ref_exec(rs, alu_src ? sign_ext : rt, pc, sign_ext, alu_op, funct, branch, is_bne);
                if (e.mul) begin pend = e; busy = 8; end
                else begin cur = e; m_valid = 1'b1; end
            end
        end
        @(negedge clk);
        idle32();
        repeat (10) @(negedge clk);
    endtask

    task automatic test_reset_mid_mul();
        bit bad = 1'b0;
        @(negedge clk);
        issue(32'h0001_2345, 32'h100, 2'b10, 6'h18);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, result, zero, carry, branch_taken, branch_target} !== 67'd0) begin
            n_fail++;
            $display("FAIL reset_mid_mul: got %h expected 0",
                     {out_valid, result, zero, carry, branch_taken, branch_target});
        end
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) bad = 1'b1;
        end
        n_checks++;
        if (bad) begin
            n_fail++; $display("FAIL reset_aborts_mul: out_valid rose after reset, expected 0");
        end
    endtask

    task automatic run_mult16(input logic [15:0] a, input logic [15:0] b, input string name);
        bit          bad = 1'b0;
        logic [31:0] p;
        p = {16'd0, a} * {16'd0, b};
        @(negedge clk);
        h_in_valid = 1'b1; h_rs = a; h_rt = b; h_alu_op = 2'b10; h_funct = 6'h18;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            h_in_valid = 1'b0;
            if (h_out_valid !== 1'b0 || h_in_ready !== 1'b0) bad = 1'b1;
        end
        n_checks++;
        if (bad) begin
            n_fail++; $display("FAIL %s_busy: early out_valid or in_ready=1, expected 0", name);
        end
        @(negedge clk);
        n_checks++;
        if ({h_out_valid, h_result, h_zero} !== {1'b1, p[15:0], (p[15:0] == 16'd0)}) begin
            n_fail++;
            $display("FAIL %s: got v=%b r=%h z=%b expected v=1 r=%h", name,
                     h_out_valid, h_result, h_zero, p[15:0]);
        end
    endtask

    initial begin
        idle32();
        h_in_valid = 1'b0; h_flush = 1'b0; h_branch = 1'b0; h_is_bne = 1'b0;
        h_alu_src = 1'b0; h_alu_op = 2'b00; h_funct = 6'h00; h_rs = 16'd0;
        h_rt = 16'd0; h_sign_ext = 16'd0; h_pc = 16'd0; h_out_ready = 1'b1;
        test_reset();
        test_add();
        test_branch();
        test_mult();
        test_backpressure();
        test_flush();
        test_random();
        test_reset_mid_mul();
        run_mult16(16'h00FF, 16'h0101, "mult16_ff_101");
        run_mult16(16'($urandom), 16'($urandom), "mult16_rand");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
